// File: rtl/temp_sensor_reader.sv
// SPI read master for the MAX6630 temperature sensor: clocks out one 16-bit
// frame per request and strobes the captured 13-bit temperature and status bits.
module temp_sensor_reader #(
    parameter int C_TEMP_SENSOR_PO_WL   = 16,
    parameter int C_TEMP_SENSOR_DATA_WL = 13,
    parameter int C_SCK_HALF_CYC        = 10,
    parameter int C_CS_SETUP_CYC        = 10,
    parameter int C_CS_IDLE_CYC         = 16
) (
    input  logic                             Clk_IN,
    input  logic                             Rst_n_IN,
    input  logic                             Start_IN,
    input  logic                             Auto_IN,
    input  logic                             Temp_sensor_SO_IN,
    output logic                             Temp_sensor_CS_OUT,
    output logic                             Temp_sensor_SCK_OUT,
    output logic [C_TEMP_SENSOR_DATA_WL-1:0] Temp_data_OUT,
    output logic [2:0]                       Temp_status_OUT,
    output logic                             Frame_error_OUT,
    output logic                             Data_valid_OUT,
    output logic                             Busy_OUT
);

    localparam int C_CYC_MAX_A = (C_SCK_HALF_CYC > C_CS_SETUP_CYC) ? C_SCK_HALF_CYC : C_CS_SETUP_CYC;
    localparam int C_CYC_MAX   = (C_CYC_MAX_A > C_CS_IDLE_CYC) ? C_CYC_MAX_A : C_CS_IDLE_CYC;
    localparam int C_CYC_W     = (C_CYC_MAX > 1) ? $clog2(C_CYC_MAX) : 1;
    localparam int C_BIT_W     = $clog2(C_TEMP_SENSOR_PO_WL + 1);

    localparam logic [C_CYC_W-1:0] C_SETUP_LAST = C_CYC_W'(C_CS_SETUP_CYC - 1);
    localparam logic [C_CYC_W-1:0] C_HALF_LAST  = C_CYC_W'(C_SCK_HALF_CYC - 1);
    localparam logic [C_CYC_W-1:0] C_IDLE_LAST  = C_CYC_W'(C_CS_IDLE_CYC - 1);
    localparam logic [C_BIT_W-1:0] C_BITS_ALL   = C_BIT_W'(C_TEMP_SENSOR_PO_WL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCK_HIGH,
        S_SCK_LOW,
        S_GAP
    } state_t;

    state_t                           r_state;
    logic [C_CYC_W-1:0]               r_cyc;
    logic [C_BIT_W-1:0]               r_bit_cnt;
    logic [C_TEMP_SENSOR_PO_WL-1:0]   r_shift;
    logic                             r_cs;
    logic                             r_sck;
    logic                             r_busy;
    logic                             r_valid;
    logic [C_TEMP_SENSOR_DATA_WL-1:0] r_data;
    logic [2:0]                       r_status;
    logic                             r_error;

    logic                             w_phase_done;
    logic [C_TEMP_SENSOR_PO_WL-1:0]   w_shift_next;

    always_comb begin
        w_phase_done = 1'b0;
        case (r_state)
            S_SETUP:              w_phase_done = (r_cyc == C_SETUP_LAST);
            S_SCK_HIGH, S_SCK_LOW: w_phase_done = (r_cyc == C_HALF_LAST);
            S_GAP:                w_phase_done = (r_cyc == C_IDLE_LAST);
            default:              w_phase_done = 1'b0;
        endcase
    end

    // SO is sampled raw: the SCK half-period already guarantees it has settled.
    assign w_shift_next = {r_shift[C_TEMP_SENSOR_PO_WL-2:0], Temp_sensor_SO_IN};

    // NOTE: the shift register sits in the async reset with everything else so a
    // mid-frame reset leaves no partial frame behind; all state uses non-blocking
    // assignments so the defaults at the top can be overridden later in the case.
    always_ff @(posedge Clk_IN or negedge Rst_n_IN) begin
        if (!Rst_n_IN) begin
            r_state   <= S_IDLE;
            r_cyc     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_status  <= '0;
            r_error   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state != S_IDLE) begin
                r_cyc <= w_phase_done ? '0 : r_cyc + C_CYC_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    r_cyc     <= '0;
                    r_bit_cnt <= '0;
                    if (Start_IN || Auto_IN) begin
                        r_state <= S_SETUP;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (w_phase_done) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + C_BIT_W'(1);
                        r_sck     <= 1'b1;
                        r_state   <= S_SCK_HIGH;
                    end
                end
                S_SCK_HIGH: begin
                    if (w_phase_done) begin
                        r_sck   <= 1'b0;
                        r_state <= S_SCK_LOW;
                    end
                end
                S_SCK_LOW: begin
                    if (w_phase_done) begin
                        if (r_bit_cnt == C_BITS_ALL) begin
                            // Final low phase doubles as the CS hold time.
                            r_cs     <= 1'b1;
                            r_data   <= r_shift[C_TEMP_SENSOR_PO_WL-1 -: C_TEMP_SENSOR_DATA_WL];
                            r_status <= r_shift[2:0];
                            r_error  <= r_shift[2];
                            r_valid  <= 1'b1;
                            r_state  <= S_GAP;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt + C_BIT_W'(1);
                            r_sck     <= 1'b1;
                            r_state   <= S_SCK_HIGH;
                        end
                    end
                end
                S_GAP: begin
                    if (w_phase_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b1;
                    r_sck   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Temp_sensor_CS_OUT  = r_cs;
    assign Temp_sensor_SCK_OUT = r_sck;
    assign Temp_data_OUT       = r_data;
    assign Temp_status_OUT     = r_status;
    assign Frame_error_OUT     = r_error;
    assign Data_valid_OUT      = r_valid;
    assign Busy_OUT            = r_busy;

endmodule

// File: doc/temp_sensor_reader.md
# temp_sensor_reader

Synthesizable SPI read master for the MAX6630MUT-T temperature sensor. It drives the sensor's CS and SCK lines and shifts in the 16-bit serial frame from SO. It extracts the 13-bit two's-complement temperature (0.0625 °C/LSB) and presents it with a one-cycle valid strobe. It sits between the sensor pins and the CPLD's housekeeping/register logic, and is verified against the team's MAX6630 behavioural sensor model.

## Interface
- C_TEMP_SENSOR_PO_WL, 16, serial frame length in bits.
- C_TEMP_SENSOR_DATA_WL, 13, temperature field width (frame MSBs).
- C_SCK_HALF_CYC, 10, clock cycles per SCK half-period (≥2).
- C_CS_SETUP_CYC, 10, cycles from CS fall to first SO sample (≥1).
- C_CS_IDLE_CYC, 16, minimum cycles CS stays high after a frame before the next frame may start (≥1).

Ports:
- Clk_IN  in  1  system clock; all logic on the rising edge.
- Rst_n_IN  in  1  asynchronous, active-low reset.
- Start_IN  in  1  single-read request, sampled in IDLE only.
- Auto_IN  in  1  level; while 1, a frame starts automatically on every IDLE cycle.
- Temp_sensor_SO_IN  in  1  sensor serial data.
- Temp_sensor_CS_OUT  out  1  sensor chip select, active low.
- Temp_sensor_SCK_OUT  out  1  sensor serial clock, idles low.
- Temp_data_OUT  out  C_TEMP_SENSOR_DATA_WL  last captured temperature, frame bits [15:3].
- Temp_status_OUT  out  3  last captured frame bits [2:0].
- Frame_error_OUT  out  1  frame bit 2 was 1 (the sensor always drives it 0).
- Data_valid_OUT  out  1  one-cycle strobe: new Temp_data/status available.
- Busy_OUT  out  1  high from frame start until the CS idle gap completes.

## Operation
- FSM states: IDLE, SETUP, SCK_HIGH, SCK_LOW, GAP.
- **IDLE**
  - CS=1, SCK=0, Busy=0.
  - If Start_IN=1 or Auto_IN=1, go to SETUP. CS=0 and Busy=1 from the next cycle.
- **SETUP**
  - CS=0, SCK=0, for C_CS_SETUP_CYC cycles.
  - On the last cycle's edge: sample SO into the shift register (bit 15), SCK→1, go to SCK_HIGH.
- **SCK_HIGH**
  - SCK=1 for C_SCK_HALF_CYC cycles, then SCK→0, go to SCK_LOW.
- **SCK_LOW**
  - SCK=0 for C_SCK_HALF_CYC cycles.
  - If bits remain: sample SO on the final edge, SCK→1, go to SCK_HIGH.
  - If all 16 bits are captured: this phase is the CS hold. On its final edge, CS→1, load the outputs, pulse Data_valid_OUT, go to GAP.
- **Sampling and shifting**
  - SO is sampled without a synchronizer, on the clock edge that drives SCK high.
  - The sensor updates SO 80 ns after each SCK falling edge.
  - Therefore both C_SCK_HALF_CYC·Tclk and C_CS_SETUP_CYC·Tclk must exceed 80 ns plus board margin.
  - Shift register is MSB first; the first sampled bit lands in bit 15.
  - A bit counter runs 0..16, sized with $clog2.
- **Output load**
  - Temp_data_OUT ← frame[15:3].
  - Temp_status_OUT ← frame[2:0].
  - Frame_error_OUT ← frame[2].
  - These hold until the next completed frame.
- **GAP**
  - CS=1, SCK=0, Busy=1, for C_CS_IDLE_CYC cycles, then IDLE.
  - Start_IN is ignored in every state except IDLE; there is no request queueing.
- **Reset (asynchronous, any state, including mid-frame)**
  - State returns to IDLE; CS=1, SCK=0.
  - Temp_data_OUT=0, Temp_status_OUT=0, Frame_error_OUT=0, Data_valid_OUT=0, Busy_OUT=0.
  - Shift register and counters are cleared. A partial frame is discarded without a valid strobe.
- Auto_IN deasserted mid-frame: the current frame completes normally; no further frame starts.
- Start_IN and Auto_IN both high: one frame, identical to either alone.

## Timing
- Let S = C_CS_SETUP_CYC and H = C_SCK_HALF_CYC.
- Start_IN sampled high at edge k: CS_OUT=0 and Busy_OUT=1 after edge k+1.
- CS_OUT stays low for exactly S + 32·H cycles.
- SCK_OUT shows exactly 16 rising edges per frame. The first rising edge is S cycles after CS falls.
- Data_valid_OUT is high for exactly one cycle: the first cycle with CS_OUT=1.
- Busy_OUT falls C_CS_IDLE_CYC cycles after CS_OUT rises.
- Auto mode frame period: 1 + S + 32·H + C_CS_IDLE_CYC cycles. With the defaults this is 347.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Single read, positive temperature**
  - Stimulus: sensor model data 13'h0190 (25 °C); pulse Start_IN.
  - Required: Temp_data_OUT=13'h0190, Frame_error_OUT=0, one Data_valid pulse.
  - Required: exactly 16 SCK rising edges; CS low for 330 cycles with the defaults.
- **Negative temperature**
  - Stimulus: sensor model data 13'h1F38 (−12.5 °C).
  - Required: Temp_data_OUT=13'h1F38.
  - Required: sign bit preserved; Temp_status_OUT[2]=0.
- **Auto mode**
  - Stimulus: Auto_IN=1 for 3 frames; model data changes 13'h0010→13'h0FF0 between frames 1 and 2.
  - Required: valid strobes 347 cycles apart; second capture = 13'h0FF0.
  - Required: CS high ≥16 cycles between frames.
- **Start while busy**
  - Stimulus: pulse Start_IN mid-frame and during GAP.
  - Required: no extra frame; exactly one Data_valid pulse.
- **Reset mid-frame**
  - Stimulus: assert Rst_n_IN low after the 7th SCK rising edge, asynchronously to Clk_IN.
  - Required: CS=1, SCK=0 and all outputs 0 immediately, with no valid pulse.
  - Required: after release, a new Start_IN completes a correct frame.
- **Frame error**
  - Stimulus: force SO bit 2 = 1 in the bench.
  - Required: Frame_error_OUT=1 with the valid strobe.
  - Required: it clears on the next good frame.
